hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_sb_entry.sv | 38 +++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and the per-source stall-need rule for the hazard scoreboard.
package hazard_pkg;

  localparam int CNT_W        = 3;
  localparam int LOAD_LAT_DEF = 2;
  localparam int ALU_LAT_DEF  = 1;

  // A branch resolves in ID and must wait for the full count. Other consumers
  // pick the value up one stage later through forwarding.
  function automatic logic [CNT_W-1:0] need_f(input logic [CNT_W-1:0] cnt,
                                              input logic             branch);
    logic [CNT_W-1:0] need;
    if (branch) begin
      need = cnt;
    end else if (cnt > CNT_W'(1)) begin
      need = cnt - CNT_W'(1);
    end else begin
      need = {CNT_W{1'b0}};
    end
    return need;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One pending-result counter. A load takes priority over the decrement, and the
// counter saturates at zero.
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next-state: load, else count down toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: per-register pending counters drive stall/bubble for ID.
// Optional HAZARD_PERF_EN adds the perf_stall_cnt stall-cycle counter port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG     = 32,
  parameter  int LOAD_LAT = LOAD_LAT_DEF,
  parameter  int ALU_LAT  = ALU_LAT_DEF,
  localparam int RW       = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_branch,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] noop_cnt,
  output logic             sb_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  logic [NREG-1:0][CNT_W-1:0] cnt_s;
  logic [NREG-1:1]            load_s;
  logic [CNT_W-1:0]           load_val_s;
  logic [CNT_W-1:0]           rs_need_s, rt_need_s, noop_s;
  logic                       stall_s, issue_s, busy_s;

  // r0 is hardwired and never tracked
  assign cnt_s[0] = {CNT_W{1'b0}};

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_s[r]),
      .load_val_i (load_val_s),
      .cnt_o      (cnt_s[r])
    );
  end

  // worst-case source need decides how many bubbles the ID instruction needs
  always_comb begin
    rs_need_s = {CNT_W{1'b0}};
    rt_need_s = {CNT_W{1'b0}};
    noop_s    = {CNT_W{1'b0}};
    if (id_rs_used) begin
      rs_need_s = need_f(cnt_s[id_rs], id_branch);
    end else begin
      rs_need_s = {CNT_W{1'b0}};
    end
    if (id_rt_used) begin
      rt_need_s = need_f(cnt_s[id_rt], id_branch);
    end else begin
      rt_need_s = {CNT_W{1'b0}};
    end
    if (id_valid && !flush) begin
      noop_s = (rs_need_s > rt_need_s) ? rs_need_s : rt_need_s;
    end else begin
      noop_s = {CNT_W{1'b0}};
    end
  end

  assign stall_s    = (noop_s != {CNT_W{1'b0}});
  assign issue_s    = id_valid & ~flush & ~stall_s;
  assign load_val_s = id_memread ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);

  // destination decode for the issuing producer, plus the busy summary
  always_comb begin
    load_s = '0;
    busy_s = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      load_s[r] = issue_s & id_regwrite & (id_rd == RW'(r));
      busy_s    = busy_s | (cnt_s[r] != {CNT_W{1'b0}});
    end
  end

  assign stall    = stall_s;
  assign bubble   = stall_s;
  assign noop_cnt = noop_s;
  assign sb_busy  = busy_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  // saturating count of stalled cycles
  always_comb begin
    perf_d = perf_q;
    if (stall_s && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // perf counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed penalty scenarios plus
// randomized traffic against a cycle-stamp reference model.
module tb_hazard_scoreboard;

  localparam int NREG     = 32;
  localparam int LOAD_LAT = 2;
  localparam int ALU_LAT  = 1;

  logic       clk = 1'b0;
  logic       rst_n, id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, id_branch, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall, bubble, sb_busy;
  logic [2:0] noop_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  // avail[r]: cycle number at which r's result is fully written back (pending count hits 0)
  int avail[NREG];
  int cyc    = 0;
  int perf_m = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_branch(id_branch),
    .flush(flush), .stall(stall), .bubble(bubble), .noop_cnt(noop_cnt), .sb_busy(sb_busy)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  function automatic int rem_of(int r);
    int v;
    if (r == 0) return 0;
    v = avail[r] - cyc;
    return (v > 0) ? v : 0;
  endfunction

  function automatic int need_m(int r, logic used);
    int rem;
    if (!used) return 0;
    rem = rem_of(r);
    if (id_branch) return rem;
    return (rem > 1) ? rem - 1 : 0;
  endfunction

  function automatic int exp_noop();
    int a, b;
    if (!id_valid || flush) return 0;
    a = need_m(int'(id_rs), id_rs_used);
    b = need_m(int'(id_rt), id_rt_used);
    return (a > b) ? a : b;
  endfunction

  function automatic logic exp_busy();
    for (int r = 1; r < NREG; r++) if (rem_of(r) > 0) return 1'b1;
    return 1'b0;
  endfunction

  // advance one clock and update the reference model with what happened at the edge
  task automatic tick();
    logic st, iss;
    st  = (exp_noop() != 0);
    iss = id_valid && !flush && !st;
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) avail[r] = 0;
      perf_m = 0;
    end else begin
      if (iss && id_regwrite && id_rd != 5'd0)
        avail[id_rd] = cyc + 1 + (id_memread ? LOAD_LAT : ALU_LAT);
      if (st) perf_m++;
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_branch = br; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    #2;
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (bubble !== 1'b0)   begin errors++; $display("FAIL reset_bubble: got %b want 0", bubble); end
    checks++; if (noop_cnt !== 3'd0) begin errors++; $display("FAIL reset_noop: got %0d want 0", noop_cnt); end
    checks++; if (sb_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", sb_busy); end
    idle(1);
  endtask

  task automatic test_load_alu();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_alu_producer_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #2;
    checks++; if (sb_busy !== 1'b1)  begin errors++; $display("FAIL ld_alu_busy: got %b want 1", sb_busy); end
    checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL ld_alu_stall: got %b want 1", stall); end
    checks++; if (bubble !== 1'b1)   begin errors++; $display("FAIL ld_alu_bubble: got %b want 1", bubble); end
    checks++; if (noop_cnt !== 3'd1) begin errors++; $display("FAIL ld_alu_noop: got %0d want 1", noop_cnt); end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_alu_issue: got %b want 0", stall); end
    tick();
    idle(3);
  endtask

  task automatic test_load_branch();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    checks++; if (noop_cnt !== 3'd2) begin errors++; $display("FAIL ld_br_noop0: got %0d want 2", noop_cnt); end
    checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL ld_br_stall0: got %b want 1", stall); end
    tick();
    #2;
    checks++; if (noop_cnt !== 3'd1) begin errors++; $display("FAIL ld_br_noop1: got %0d want 1", noop_cnt); end
    checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL ld_br_stall1: got %b want 1", stall); end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_br_issue: got %b want 0", stall); end
    tick();
    idle(3);
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_alu_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    checks++; if (noop_cnt !== 3'd1) begin errors++; $display("FAIL alu_br_noop: got %0d want 1", noop_cnt); end
    checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL alu_br_stall: got %b want 1", stall); end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_br_issue: got %b want 0", stall); end
    tick();
    idle(3);
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    #2;
    checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL r0_stall: got %b want 0", stall); end
    checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL r0_busy: got %b want 0", sb_busy); end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic test_flush_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    #2;
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
    checks++; if (noop_cnt !== 3'd0) begin errors++; $display("FAIL flush_noop: got %0d want 0", noop_cnt); end
    tick();
    flush = 1'b0;
    // r9 must not have been loaded by the flushed instruction
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_noload: got %b want 0", stall); end
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_after_stall: got %b want 1", stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL midstall_reset_stall: got %b want 0", stall); end
    checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL midstall_reset_busy: got %b want 0", sb_busy); end
    tick();
    idle(3);
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    idle(1);
    #2;
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_cnt: got %0d want 3", perf_stall_cnt); end
  endtask
`endif

  task automatic test_random();
    int en;
    logic hold;
    for (int i = 0; i < 600; i++) begin
      hold = (exp_noop() != 0) && ($urandom_range(0, 3) != 0);
      if (!hold) begin
        id_valid    = ($urandom_range(0, 7) != 0);
        id_rs       = 5'($urandom_range(0, 7));
        id_rt       = 5'($urandom_range(0, 7));
        id_rd       = 5'($urandom_range(0, 7));
        id_rs_used  = 1'($urandom_range(0, 1));
        id_rt_used  = 1'($urandom_range(0, 1));
        id_regwrite = 1'($urandom_range(0, 1));
        id_memread  = id_regwrite & 1'($urandom_range(0, 1));
        id_branch   = ($urandom_range(0, 3) == 0);
      end
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      #2;
      en = exp_noop();
      checks++; if (noop_cnt !== 3'(en))      begin errors++; $display("FAIL rnd_noop@%0d: got %0d want %0d", i, noop_cnt, en); end
      checks++; if (stall !== (en != 0))      begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", i, stall, (en != 0)); end
      checks++; if (bubble !== (en != 0))     begin errors++; $display("FAIL rnd_bubble@%0d: got %b want %b", i, bubble, (en != 0)); end
      checks++; if (sb_busy !== exp_busy())   begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", i, sb_busy, exp_busy()); end
`ifdef HAZARD_PERF_EN
      checks++; if (perf_stall_cnt !== 32'(perf_m)) begin errors++; $display("FAIL rnd_perf@%0d: got %0d want %0d", i, perf_stall_cnt, perf_m); end
`endif
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) avail[r] = 0;
    test_reset();
    test_load_alu();
    test_load_branch();
    test_alu();
    test_r0();
    test_flush_reset();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
